// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder
//   Memory-side responder for the single-cycle RV32I core. Owns the IM and DM
//   word arrays, serves zero-latency reads, performs byte-lane DM writes on the
//   clock edge, fills both arrays from a bench loader while the core is held in
//   reset, and halts on a full-word write to the tohost mailbox (last DM word).
// Ports
//   clk, rst                  clock, async active-low reset
//   IM_A / IM_DO              instruction read port (combinational)
//   DM_OE, DM_A, DM_WEB,
//   DM_DI / DM_DO             data port; DM_WEB active-low per-byte enables
//   ld_valid_i/ld_ready_o,
//   ld_sel_i, ld_addr_i,
//   ld_data_i, ld_last_i      loader (0 = IM, 1 = DM), one word per cycle
//   cpu_rst_o                 active-low core reset
//   done_o, tohost_o          mailbox written / captured value
//   run_cycles_o              saturating count of RUN cycles
module cpu_mem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int IM_DEPTH   = 16384,
  parameter int DM_DEPTH   = 16384,
  localparam int IM_AW = $clog2(IM_DEPTH),
  localparam int DM_AW = $clog2(DM_DEPTH),
  localparam int LD_AW = $clog2((IM_DEPTH > DM_DEPTH) ? IM_DEPTH : DM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IM_AW-1:0]      IM_A,
  output logic [DATA_WIDTH-1:0] IM_DO,
  input  logic                  DM_OE,
  input  logic [DM_AW-1:0]      DM_A,
  input  logic [3:0]            DM_WEB,
  input  logic [DATA_WIDTH-1:0] DM_DI,
  output logic [DATA_WIDTH-1:0] DM_DO,
  input  logic                  ld_valid_i,
  output logic                  ld_ready_o,
  input  logic                  ld_sel_i,
  input  logic [LD_AW-1:0]      ld_addr_i,
  input  logic [DATA_WIDTH-1:0] ld_data_i,
  input  logic                  ld_last_i,
  output logic                  cpu_rst_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] tohost_o,
  output logic [31:0]           run_cycles_o
);

  localparam int LANES  = 4;
  localparam int LANE_W = DATA_WIDTH / LANES;

  typedef enum logic [1:0] {S_LOAD, S_RUN, S_HALT} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] tohost_q, tohost_d;
  logic [31:0]           run_cycles_q, run_cycles_d;

  logic [DATA_WIDTH-1:0] im_mem [IM_DEPTH];
  logic [DATA_WIDTH-1:0] dm_mem [DM_DEPTH];

  logic                  ld_xfer;
  logic                  mbox_hit;
  logic                  im_we;
  logic [IM_AW-1:0]      im_waddr;
  logic [LANES-1:0]      dm_lane_we;
  logic [DM_AW-1:0]      dm_waddr;
  logic [DATA_WIDTH-1:0] dm_wdata;

  // Upper loader address bits are dropped for the smaller array (wrap).
  logic unused_ld_addr;
  assign unused_ld_addr = ^ld_addr_i;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_LOAD;
      tohost_q     <= '0;
      run_cycles_q <= '0;
    end else begin
      state_q      <= state_d;
      tohost_q     <= tohost_d;
      run_cycles_q <= run_cycles_d;
    end
  end

  // Handshake / mailbox decode
  always_comb begin
    ld_xfer  = ld_valid_i && (state_q == S_LOAD);
    // Only a full-word RUN write to the last DM word halts the core.
    mbox_hit = (state_q == S_RUN) && (DM_WEB == 4'h0) &&
               (DM_A == DM_AW'(DM_DEPTH - 1));
  end

  // Next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD:  if (ld_xfer && ld_last_i) state_d = S_RUN;
      S_RUN:   if (mbox_hit)             state_d = S_HALT;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_LOAD;
    endcase
  end

  always_comb begin
    tohost_d     = mbox_hit ? DM_DI : tohost_q;
    run_cycles_d = run_cycles_q;
    if (state_q == S_RUN && run_cycles_q != 32'hFFFF_FFFF)
      run_cycles_d = run_cycles_q + 32'd1;
  end

  // Outputs
  always_comb begin
    ld_ready_o   = (state_q == S_LOAD);
    cpu_rst_o    = (state_q != S_LOAD);
    done_o       = (state_q == S_HALT);
    tohost_o     = tohost_q;
    run_cycles_o = run_cycles_q;
  end

  // Array write port selection: loader owns both arrays in LOAD, the core
  // owns DM in RUN, nothing writes in HALT.
  always_comb begin
    im_we      = ld_xfer && !ld_sel_i;
    im_waddr   = ld_addr_i[IM_AW-1:0];
    dm_lane_we = '0;
    dm_waddr   = DM_A;
    dm_wdata   = DM_DI;
    if (state_q == S_LOAD) begin
      dm_lane_we = {LANES{ld_xfer && ld_sel_i}};
      dm_waddr   = ld_addr_i[DM_AW-1:0];
      dm_wdata   = ld_data_i;
    end else if (state_q == S_RUN) begin
      dm_lane_we = ~DM_WEB;
    end
  end

  // Arrays are never reset so a program survives rst.
  always_ff @(posedge clk) begin
    if (im_we) im_mem[im_waddr] <= ld_data_i;
    for (int i = 0; i < LANES; i++)
      if (dm_lane_we[i])
        dm_mem[dm_waddr][i*LANE_W +: LANE_W] <= dm_wdata[i*LANE_W +: LANE_W];
  end

  // Reads are combinational, so a same-cycle write shows old data.
  always_comb begin
    IM_DO = im_mem[IM_A];
    DM_DO = DM_OE ? dm_mem[DM_A] : '0;
  end

endmodule

// File: tb/tb_cpu_mem_responder.sv
module tb_cpu_mem_responder;
  localparam int IMD = 64;
  localparam int DMD = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  IM_A = '0;
  logic [31:0] IM_DO;
  logic        DM_OE = 1'b0;
  logic [4:0]  DM_A = '0;
  logic [3:0]  DM_WEB = 4'hF;
  logic [31:0] DM_DI = '0;
  logic [31:0] DM_DO;
  logic        ld_valid_i = 1'b0;
  logic        ld_ready_o;
  logic        ld_sel_i = 1'b0;
  logic [5:0]  ld_addr_i = '0;
  logic [31:0] ld_data_i = '0;
  logic        ld_last_i = 1'b0;
  logic        cpu_rst_o;
  logic        done_o;
  logic [31:0] tohost_o;
  logic [31:0] run_cycles_o;

  always #5 clk = ~clk;

  cpu_mem_responder #(.DATA_WIDTH(32), .IM_DEPTH(IMD), .DM_DEPTH(DMD)) dut (
    .clk(clk), .rst(rst), .IM_A(IM_A), .IM_DO(IM_DO), .DM_OE(DM_OE), .DM_A(DM_A),
    .DM_WEB(DM_WEB), .DM_DI(DM_DI), .DM_DO(DM_DO), .ld_valid_i(ld_valid_i),
    .ld_ready_o(ld_ready_o), .ld_sel_i(ld_sel_i), .ld_addr_i(ld_addr_i),
    .ld_data_i(ld_data_i), .ld_last_i(ld_last_i), .cpu_rst_o(cpu_rst_o),
    .done_o(done_o), .tohost_o(tohost_o), .run_cycles_o(run_cycles_o));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h @%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 = loading, 1 = running, 2 = halted.
  int          ph = 0;
  logic [31:0] m_tohost = '0;
  logic [31:0] m_cyc = '0;
  logic [31:0] im_m [IMD];
  logic        im_kn [IMD] = '{default: 1'b0};
  logic [31:0] dm_m [DMD];
  logic [3:0]  dm_kn [DMD] = '{default: 4'h0};

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ph <= 0; m_tohost <= '0; m_cyc <= '0;
    end else if (ph == 0) begin
      if (ld_valid_i) begin
        if (ld_sel_i) begin
          dm_m[int'(ld_addr_i) % DMD]  <= ld_data_i;
          dm_kn[int'(ld_addr_i) % DMD] <= 4'hF;
        end else begin
          im_m[int'(ld_addr_i) % IMD]  <= ld_data_i;
          im_kn[int'(ld_addr_i) % IMD] <= 1'b1;
        end
        if (ld_last_i) ph <= 1;
      end
    end else if (ph == 1) begin
      if (m_cyc != 32'hFFFF_FFFF) m_cyc <= m_cyc + 32'd1;
      for (int i = 0; i < 4; i++)
        if (!DM_WEB[i]) begin
          dm_m[DM_A][8*i +: 8] <= DM_DI[8*i +: 8];
          dm_kn[DM_A][i]       <= 1'b1;
        end
      if (DM_WEB == 4'h0 && int'(DM_A) == DMD - 1) begin
        m_tohost <= DM_DI;
        ph       <= 2;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic [31:0] mask;
    chk("cpu_rst_o", 32'(cpu_rst_o), 32'(ph != 0));
    chk("ld_ready_o", 32'(ld_ready_o), 32'(ph == 0));
    chk("done_o", 32'(done_o), 32'(ph == 2));
    chk("tohost_o", tohost_o, m_tohost);
    chk("run_cycles_o", run_cycles_o, m_cyc);
    if (im_kn[IM_A]) chk("IM_DO", IM_DO, im_m[IM_A]);
    if (!DM_OE) chk("DM_DO_off", DM_DO, 32'h0);
    else if (dm_kn[DM_A] != 4'h0) begin
      mask = {{8{dm_kn[DM_A][3]}}, {8{dm_kn[DM_A][2]}}, {8{dm_kn[DM_A][1]}}, {8{dm_kn[DM_A][0]}}};
      chk("DM_DO", DM_DO & mask, dm_m[DM_A] & mask);
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic ld(input logic sel, input int addr, input logic [31:0] data, input logic last);
    ld_valid_i = 1'b1; ld_sel_i = sel; ld_addr_i = 6'(addr);
    ld_data_i = data; ld_last_i = last;
    step();
    ld_valid_i = 1'b0; ld_last_i = 1'b0;
  endtask

  initial begin
    int n;
    #1;
    chk("rst cpu_rst_o", 32'(cpu_rst_o), 32'h0);
    chk("rst ld_ready_o", 32'(ld_ready_o), 32'h1);
    chk("rst done_o", 32'(done_o), 32'h0);
    chk("rst tohost_o", tohost_o, 32'h0);
    chk("rst run_cycles_o", run_cycles_o, 32'h0);
    step(); step();
    rst = 1'b1;

    // Fill DM, then one wrapped address (37 -> 5).
    for (int i = 0; i < DMD; i++) ld(1'b1, i, 32'hC0DE_0000 | 32'(i), 1'b0);
    ld(1'b1, 37, 32'h5555_0005, 1'b0);
    // Core-side DM writes must be ignored while loading.
    DM_WEB = 4'h0; DM_A = 5'd7; DM_DI = 32'hFFFF_FFFF;
    for (int i = 3; i < 8; i++) ld(1'b0, i, 32'h0000_0100 + 32'(i), 1'b0);
    DM_WEB = 4'hF;
    ld(1'b0, 0, 32'h0000_0013, 1'b0);
    ld(1'b0, 1, 32'h0000_0013, 1'b0);
    DM_OE = 1'b1; DM_A = 5'd5; #1;
    chk("wrap load DM[5]", DM_DO, 32'h5555_0005);
    ld(1'b0, 2, 32'h0000_0013, 1'b1);
    chk("run cpu_rst_o", 32'(cpu_rst_o), 32'h1);
    chk("run ld_ready_o", 32'(ld_ready_o), 32'h0);
    chk("run start cycles", run_cycles_o, 32'h0);
    IM_A = 6'd1; #1;
    chk("IM[1]", IM_DO, 32'h0000_0013);
    step();
    chk("one RUN cycle", run_cycles_o, 32'h1);

    // Byte-lane write and read-during-write.
    DM_A = 5'd5; DM_WEB = 4'h0; DM_DI = 32'hAABB_CCDD; step();
    DM_WEB = 4'b1101; DM_DI = 32'h0000_1100; #1;
    chk("old data in write cycle", DM_DO, 32'hAABB_CCDD);
    step(); DM_WEB = 4'hF; #1;
    chk("lane1 write", DM_DO, 32'hAABB_11DD);
    DM_A = 5'd7; #1;
    chk("DM[7] untouched by LOAD-time core write", DM_DO, 32'hC0DE_0007);
    DM_OE = 1'b0; #1;
    chk("DM_OE=0", DM_DO, 32'h0);

    // Loader pulses during RUN are dropped.
    ld(1'b0, 1, 32'hDEAD_BEEF, 1'b0);
    ld(1'b1, 5, 32'hDEAD_BEEF, 1'b0);
    IM_A = 6'd1; DM_OE = 1'b1; DM_A = 5'd5; #1;
    chk("IM after RUN ld", IM_DO, 32'h0000_0013);
    chk("DM after RUN ld", DM_DO, 32'hAABB_11DD);

    // Partial mailbox write: no halt.
    DM_A = 5'd31; DM_WEB = 4'b1110; DM_DI = 32'h0000_00AB; step();
    DM_WEB = 4'hF; #1;
    chk("partial mbox done_o", 32'(done_o), 32'h0);
    chk("partial mbox data", DM_DO, 32'hC0DE_00AB);

    n = 0;
    while (run_cycles_o != 32'd40 && n < 200) begin step(); n++; end
    chk("reach 40 cycles", run_cycles_o, 32'd40);

    // Async reset mid-RUN.
    rst = 1'b0; #1;
    chk("arst cpu_rst_o", 32'(cpu_rst_o), 32'h0);
    chk("arst ld_ready_o", 32'(ld_ready_o), 32'h1);
    chk("arst done_o", 32'(done_o), 32'h0);
    chk("arst tohost_o", tohost_o, 32'h0);
    chk("arst run_cycles_o", run_cycles_o, 32'h0);
    step();
    rst = 1'b1;
    ld(1'b0, 10, 32'h0000_0ABC, 1'b1);
    chk("restart cpu_rst_o", 32'(cpu_rst_o), 32'h1);
    IM_A = 6'd0; #1;
    chk("IM[0] kept", IM_DO, 32'h0000_0013);
    IM_A = 6'd10; #1;
    chk("IM[10] restart word", IM_DO, 32'h0000_0ABC);

    // Full mailbox write halts.
    DM_A = 5'd31; DM_WEB = 4'h0; DM_DI = 32'h0000_0001; step();
    chk("halt done_o", 32'(done_o), 32'h1);
    chk("halt tohost_o", tohost_o, 32'h0000_0001);
    DM_A = 5'd0; DM_DI = 32'hFFFF_FFFF;
    ld_valid_i = 1'b1; ld_sel_i = 1'b0; ld_addr_i = 6'd0; ld_data_i = 32'h0; ld_last_i = 1'b1;
    step(); step();
    DM_WEB = 4'hF; ld_valid_i = 1'b0; ld_last_i = 1'b0; IM_A = 6'd0; #1;
    chk("HALT DM write ignored", DM_DO, 32'hC0DE_0000);
    chk("HALT ld ignored", IM_DO, 32'h0000_0013);
    chk("HALT cycles hold", run_cycles_o, 32'h1);
    chk("HALT cpu_rst_o", 32'(cpu_rst_o), 32'h1);
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
